// File: rtl/deser_channel_arbiter_if.sv
// Bundle of the per-channel write streams and the merged valid/ready output
// stream of deser_channel_arbiter.
interface deser_channel_arbiter_if #(
    parameter int unsigned NCH = 4
);
    logic [NCH-1:0]    en;
    logic              flush;
    logic [NCH-1:0]    wr;
    logic [16*NCH-1:0] din;
    logic [15:0]       dout;
    logic [1:0]        dout_chan;
    logic              dout_valid;
    logic              dout_ready;
    logic [NCH-1:0]    overflow;
    logic              busy;

    modport master (
        output en, flush, wr, din, dout_ready,
        input  dout, dout_chan, dout_valid, overflow, busy
    );

    modport slave (
        input  en, flush, wr, din, dout_ready,
        output dout, dout_chan, dout_valid, overflow, busy
    );
endinterface

// File: rtl/deser_channel_arbiter.sv
// Merges up to four decoder word streams through per-channel FIFOs and a
// round-robin, burst-limited arbiter into one channel-tagged output stream.
module deser_channel_arbiter #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned AW       = 4,
    parameter int unsigned MAXBURST = 8
) (
    input  logic                    clk80,
    input  logic                    reset_n,
    deser_channel_arbiter_if.slave  bus
);
    localparam int unsigned DEPTH   = 1 << AW;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t         r_state, w_state_nxt;
    logic [1:0]     r_grant, w_grant_nxt;
    logic [1:0]     r_last, w_last_nxt;
    logic [7:0]     r_burst, w_burst_nxt;

    logic [15:0]    r_mem  [NCH][DEPTH];
    logic [AW-1:0]  r_wptr [NCH];
    logic [AW-1:0]  r_rptr [NCH];
    logic [AW:0]    r_cnt  [NCH];
    logic [NCH-1:0] r_ovf;

    logic [15:0]    r_dout;
    logic [1:0]     r_chan;
    logic           r_valid;

    logic [NCH-1:0] w_empty, w_full, w_push, w_pop;
    logic           w_slot_free, w_pop_any;
    logic           w_found;
    logic [1:0]     w_found_ch;

    always_comb begin
        for (int unsigned k = 0; k < NCH; k++) begin
            w_empty[k] = (r_cnt[k] == '0);
            w_full[k]  = r_cnt[k][AW];
            w_push[k]  = bus.en[k] & bus.wr[k] & ~w_full[k];
        end
    end

    assign w_slot_free = ~r_valid | bus.dout_ready;
    assign w_pop_any   = (r_state == S_GRANT) && w_slot_free && !w_empty[r_grant];
    assign w_pop       = w_pop_any ? (NCH'(1) << r_grant) : '0;

    // Rotating search starting just after the last granted channel.
    always_comb begin : search
        int unsigned idx;
        w_found    = 1'b0;
        w_found_ch = r_last;
        for (int unsigned i = 1; i <= NCH; i++) begin
            idx = (int'(r_last) + i) % NCH;
            if (!w_found && !w_empty[idx]) begin
                w_found    = 1'b1;
                w_found_ch = 2'(idx);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_burst_nxt = r_burst;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                    w_grant_nxt = w_found_ch;
                    w_burst_nxt = '0;
                end
            end
            S_GRANT: begin
                if (w_empty[r_grant]) begin
                    w_state_nxt = S_IDLE;
                    w_last_nxt  = r_grant;
                end else if (w_slot_free) begin
                    w_burst_nxt = r_burst + 8'd1;
                    // A same-cycle write keeps the FIFO non-empty after the pop.
                    if ((r_cnt[r_grant] == CNT_ONE && !w_push[r_grant]) ||
                        w_burst_nxt == 8'(MAXBURST)) begin
                        w_state_nxt = S_IDLE;
                        w_last_nxt  = r_grant;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk80 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= 2'(NCH - 1);
            r_burst <= '0;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= 2'(NCH - 1);
            r_burst <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            r_burst <= w_burst_nxt;
        end
    end

    always_ff @(posedge clk80 or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                r_wptr[k] <= '0;
                r_rptr[k] <= '0;
                r_cnt[k]  <= '0;
            end
            r_ovf <= '0;
        end else if (bus.flush) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                r_wptr[k] <= '0;
                r_rptr[k] <= '0;
                r_cnt[k]  <= '0;
            end
            r_ovf <= '0;
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                if (w_push[k]) r_wptr[k] <= r_wptr[k] + PTR_ONE;
                if (w_pop[k])  r_rptr[k] <= r_rptr[k] + PTR_ONE;
                case ({w_push[k], w_pop[k]})
                    2'b10:   r_cnt[k] <= r_cnt[k] + CNT_ONE;
                    2'b01:   r_cnt[k] <= r_cnt[k] - CNT_ONE;
                    default: r_cnt[k] <= r_cnt[k];
                endcase
                if (bus.en[k] && bus.wr[k] && w_full[k]) r_ovf[k] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk80) begin
        for (int unsigned k = 0; k < NCH; k++) begin
            if (w_push[k] && !bus.flush) r_mem[k][r_wptr[k]] <= bus.din[16*k +: 16];
        end
    end

    always_ff @(posedge clk80 or negedge reset_n) begin
        if (!reset_n) begin
            r_dout  <= '0;
            r_chan  <= '0;
            r_valid <= 1'b0;
        end else if (bus.flush) begin
            r_dout  <= '0;
            r_chan  <= '0;
            r_valid <= 1'b0;
        end else if (w_pop_any) begin
            r_dout  <= r_mem[r_grant][r_rptr[r_grant]];
            r_chan  <= r_grant;
            r_valid <= 1'b1;
        end else if (w_slot_free) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_chan  = r_chan;
    assign bus.dout_valid = r_valid;
    assign bus.overflow   = r_ovf;
    assign bus.busy       = (~&w_empty) | r_valid | (r_state == S_GRANT);
endmodule
